// File: rtl/bram_addr_gen_pkg.sv
// -----------------------------------------------------------------------------
// bram_addr_gen_pkg
//   Shared definitions for the BRAM address generator: FSM state encoding
//   and the state type used by bram_addr_gen_fsm.
// -----------------------------------------------------------------------------
package bram_addr_gen_pkg;

  localparam int STATE_W = 2;

  localparam logic [STATE_W-1:0] ST_IDLE_ENC = 2'd0;
  localparam logic [STATE_W-1:0] ST_RUN_ENC  = 2'd1;
  localparam logic [STATE_W-1:0] ST_DONE_ENC = 2'd2;

  typedef enum logic [STATE_W-1:0] {
    IDLE = ST_IDLE_ENC,
    RUN  = ST_RUN_ENC,
    DONE = ST_DONE_ENC
  } state_t;

endpackage

// File: rtl/bram_addr_gen_fsm.sv
// -----------------------------------------------------------------------------
// bram_addr_gen_fsm
//   Control FSM for the BRAM address generator (IDLE -> RUN -> DONE -> IDLE).
//   State flags are registered alongside the state so they are one-hot and
//   glitch-free.
//
// Ports
//   clk         in   clock, rising edge
//   reset       in   synchronous, active-high
//   start_i     in   start request (honoured in IDLE only)
//   cnt_zero_i  in   requested access count is zero
//   last_acc_i  in   the access completing the latched count happens this cycle
//   abort_i     in   cancel the active transfer (honoured in RUN only)
//   idle_o      out  FSM in IDLE
//   run_o       out  FSM in RUN
//   done_o      out  FSM in DONE (one-cycle pulse)
// -----------------------------------------------------------------------------
module bram_addr_gen_fsm
  import bram_addr_gen_pkg::*;
(
  input  logic clk,
  input  logic reset,
  input  logic start_i,
  input  logic cnt_zero_i,
  input  logic last_acc_i,
  input  logic abort_i,
  output logic idle_o,
  output logic run_o,
  output logic done_o
);

  state_t state;

  always_ff @(posedge clk) begin
    if (reset) begin
      state  <= IDLE;
      idle_o <= 1'b1;
      run_o  <= 1'b0;
      done_o <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (start_i && cnt_zero_i) begin
            state  <= DONE;
            idle_o <= 1'b0;
            run_o  <= 1'b0;
            done_o <= 1'b1;
          end else if (start_i) begin
            state  <= RUN;
            idle_o <= 1'b0;
            run_o  <= 1'b1;
            done_o <= 1'b0;
          end
        end
        RUN: begin
          // Abort wins over a coincident final access: no done pulse.
          if (abort_i) begin
            state  <= IDLE;
            idle_o <= 1'b1;
            run_o  <= 1'b0;
            done_o <= 1'b0;
          end else if (last_acc_i) begin
            state  <= DONE;
            idle_o <= 1'b0;
            run_o  <= 1'b0;
            done_o <= 1'b1;
          end
        end
        DONE: begin
          state  <= IDLE;
          idle_o <= 1'b1;
          run_o  <= 1'b0;
          done_o <= 1'b0;
        end
        default: begin
          state  <= IDLE;
          idle_o <= 1'b1;
          run_o  <= 1'b0;
          done_o <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: rtl/bram_addr_gen.sv
// -----------------------------------------------------------------------------
// bram_addr_gen
//   Strided BRAM address generator. A start in IDLE latches base, stride and
//   access count; RUN then presents one address per cycle, advancing on each
//   accepted access (addr_vld_o && en_i). DONE pulses for one cycle after the
//   last access. abort_i returns to IDLE without a done pulse.
//
//   Optional feature: define BRAM_ADDR_GEN_WRAP_EN to add wrap_lim_i; the
//   address then wraps past the latched limit instead of modulo 2^AWIDTH.
//
// Ports
//   clk          in   clock, rising edge
//   reset        in   synchronous, active-high
//   start_i      in   begin a transfer (sampled in IDLE)
//   base_addr_i  in   first address, latched on start
//   stride_i     in   per-access increment, latched on start
//   cnt_val_i    in   number of accesses, latched on start
//   wrap_lim_i   in   wrap limit, latched on start (BRAM_ADDR_GEN_WRAP_EN only)
//   en_i         in   consumer ready
//   abort_i      in   cancel active transfer
//   addr_o       out  current address
//   addr_vld_o   out  address valid (== run_o)
//   acc_cnt_o    out  accesses completed in current/last transfer
//   idle_o/run_o/done_o  out  one-hot FSM state flags
// -----------------------------------------------------------------------------
module bram_addr_gen
  import bram_addr_gen_pkg::*;
#(
  parameter int AWIDTH  = 8,
  parameter int CNT_BIT = 31
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               start_i,
  input  logic [AWIDTH-1:0]  base_addr_i,
  input  logic [AWIDTH-1:0]  stride_i,
  input  logic [CNT_BIT-1:0] cnt_val_i,
`ifdef BRAM_ADDR_GEN_WRAP_EN
  input  logic [AWIDTH-1:0]  wrap_lim_i,
`endif
  input  logic               en_i,
  input  logic               abort_i,
  output logic [AWIDTH-1:0]  addr_o,
  output logic               addr_vld_o,
  output logic [CNT_BIT-1:0] acc_cnt_o,
  output logic               idle_o,
  output logic               run_o,
  output logic               done_o
);

  localparam logic [CNT_BIT-1:0] CNT_ONE = CNT_BIT'(1);

`ifdef BRAM_ADDR_GEN_WRAP_EN
  // Sum is formed one bit wider so a carry out counts as exceeding the limit.
  function automatic logic [AWIDTH-1:0] next_addr(
    input logic [AWIDTH-1:0] a,
    input logic [AWIDTH-1:0] s,
    input logic [AWIDTH-1:0] lim
  );
    logic [AWIDTH:0] sum;
    logic [AWIDTH:0] lim_w;
    sum   = {1'b0, a} + {1'b0, s};
    lim_w = {1'b0, lim};
    if (sum <= lim_w)
      next_addr = AWIDTH'(sum);
    else
      next_addr = AWIDTH'(sum - lim_w - {{AWIDTH{1'b0}}, 1'b1});
  endfunction
`else
  function automatic logic [AWIDTH-1:0] next_addr(
    input logic [AWIDTH-1:0] a,
    input logic [AWIDTH-1:0] s
  );
    next_addr = a + s;
  endfunction
`endif

  logic [AWIDTH-1:0]  addr_p0;
  logic [CNT_BIT-1:0] acc_cnt_p0;
  logic [AWIDTH-1:0]  stride_p0;
  logic [CNT_BIT-1:0] cnt_lat_p0;
`ifdef BRAM_ADDR_GEN_WRAP_EN
  logic [AWIDTH-1:0]  wrap_lim_p0;
`endif

  logic               cnt_zero;
  logic               accept;
  logic               fire;
  logic               last_acc;
  logic [CNT_BIT-1:0] acc_inc;
  logic [AWIDTH-1:0]  addr_nxt;

  assign cnt_zero = (cnt_val_i == '0);
  assign accept   = idle_o & start_i;
  // An access completes only if it is not cancelled by a coincident abort.
  assign fire     = run_o & en_i & ~abort_i;
  assign acc_inc  = acc_cnt_p0 + CNT_ONE;
  assign last_acc = run_o & en_i & (acc_inc == cnt_lat_p0);

`ifdef BRAM_ADDR_GEN_WRAP_EN
  assign addr_nxt = next_addr(addr_p0, stride_p0, wrap_lim_p0);
`else
  assign addr_nxt = next_addr(addr_p0, stride_p0);
`endif

  bram_addr_gen_fsm u_fsm (
    .clk        (clk),
    .reset      (reset),
    .start_i    (start_i),
    .cnt_zero_i (cnt_zero),
    .last_acc_i (last_acc),
    .abort_i    (abort_i),
    .idle_o     (idle_o),
    .run_o      (run_o),
    .done_o     (done_o)
  );

  // Stage p0: transfer configuration, latched on an accepted start
  always_ff @(posedge clk) begin
    if (accept) begin
      stride_p0  <= stride_i;
      cnt_lat_p0 <= cnt_val_i;
`ifdef BRAM_ADDR_GEN_WRAP_EN
      wrap_lim_p0 <= wrap_lim_i;
`endif
    end
  end

  // Stage p0: address and access counter
  always_ff @(posedge clk) begin
    if (reset) begin
      addr_p0    <= '0;
      acc_cnt_p0 <= '0;
    end else if (accept) begin
      acc_cnt_p0 <= '0;
      // A zero-length transfer issues no address, so the old one is kept.
      if (!cnt_zero)
        addr_p0 <= base_addr_i;
    end else if (fire) begin
      addr_p0    <= addr_nxt;
      acc_cnt_p0 <= acc_inc;
    end
  end

  assign addr_o     = addr_p0;
  assign acc_cnt_o  = acc_cnt_p0;
  assign addr_vld_o = run_o;

endmodule

// File: tb/tb_bram_addr_gen.sv
module tb_bram_addr_gen;

  localparam int AW = 8;
  localparam int CW = 31;

  localparam logic [2:0] SI = 3'b100;  // {idle, run, done}
  localparam logic [2:0] SR = 3'b010;
  localparam logic [2:0] SD = 3'b001;

  typedef struct packed {
    logic          start;
    logic          en;
    logic          abort;
    logic          rst;
    logic [2:0]    st;
    logic [AW-1:0] addr;
    logic [CW-1:0] acc;
  } step_t;

  logic          clk = 1'b0;
  logic          reset = 1'b0;
  logic          start_i = 1'b0;
  logic [AW-1:0] base_addr_i = '0;
  logic [AW-1:0] stride_i = '0;
  logic [CW-1:0] cnt_val_i = '0;
  logic [AW-1:0] wrap_lim_i = '0;
  logic          en_i = 1'b0;
  logic          abort_i = 1'b0;
  logic [AW-1:0] addr_o;
  logic          addr_vld_o;
  logic [CW-1:0] acc_cnt_o;
  logic          idle_o, run_o, done_o;

  int checks = 0;
  int errors = 0;
  step_t q[$];

  always #5 clk = ~clk;

  bram_addr_gen #(.AWIDTH(AW), .CNT_BIT(CW)) dut (
    .clk         (clk),
    .reset       (reset),
    .start_i     (start_i),
    .base_addr_i (base_addr_i),
    .stride_i    (stride_i),
    .cnt_val_i   (cnt_val_i),
`ifdef BRAM_ADDR_GEN_WRAP_EN
    .wrap_lim_i  (wrap_lim_i),
`endif
    .en_i        (en_i),
    .abort_i     (abort_i),
    .addr_o      (addr_o),
    .addr_vld_o  (addr_vld_o),
    .acc_cnt_o   (acc_cnt_o),
    .idle_o      (idle_o),
    .run_o       (run_o),
    .done_o      (done_o)
  );

  function automatic step_t mk(input logic s, input logic e, input logic a, input logic r,
                               input logic [2:0] st, input logic [AW-1:0] ad, input int ac);
    mk = '{start: s, en: e, abort: a, rst: r, st: st, addr: ad, acc: CW'(ac)};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    base_addr_i = 8'h33; stride_i = 8'h01; cnt_val_i = 2;
    q = {};
    q.push_back(mk(1, 1, 0, 1, SI, 8'h00, 0));
    q.push_back(mk(1, 1, 0, 1, SI, 8'h00, 0));
    q.push_back(mk(0, 1, 0, 0, SI, 8'h00, 0));
    q.push_back(mk(0, 1, 1, 0, SI, 8'h00, 0));
    foreach (q[i]) begin
      start_i = q[i].start; en_i = q[i].en; abort_i = q[i].abort; reset = q[i].rst;
      tick();
      checks++;
      if ({idle_o, run_o, done_o} !== q[i].st || addr_vld_o !== q[i].st[1] ||
          addr_o !== q[i].addr || acc_cnt_o !== q[i].acc) begin
        errors++;
        $display("FAIL reset step %0d: got flags=%b vld=%b addr=%h acc=%0d, want flags=%b addr=%h acc=%0d",
                 i, {idle_o, run_o, done_o}, addr_vld_o, addr_o, acc_cnt_o, q[i].st, q[i].addr, q[i].acc);
      end
    end
    start_i = 0; abort_i = 0;
  endtask

  task automatic test_basic();
    base_addr_i = 8'h10; stride_i = 8'h01; cnt_val_i = 4;
    q = {};
    q.push_back(mk(1, 1, 0, 0, SR, 8'h10, 0));
    q.push_back(mk(0, 1, 0, 0, SR, 8'h11, 1));
    q.push_back(mk(0, 1, 0, 0, SR, 8'h12, 2));
    q.push_back(mk(0, 1, 0, 0, SR, 8'h13, 3));
    q.push_back(mk(0, 1, 0, 0, SD, 8'h14, 4));
    q.push_back(mk(0, 1, 0, 0, SI, 8'h14, 4));
    q.push_back(mk(0, 1, 0, 0, SI, 8'h14, 4));
    foreach (q[i]) begin
      start_i = q[i].start; en_i = q[i].en; abort_i = q[i].abort; reset = q[i].rst;
      tick();
      checks++;
      if ({idle_o, run_o, done_o} !== q[i].st || addr_vld_o !== q[i].st[1] ||
          addr_o !== q[i].addr || acc_cnt_o !== q[i].acc) begin
        errors++;
        $display("FAIL basic step %0d: got flags=%b vld=%b addr=%h acc=%0d, want flags=%b addr=%h acc=%0d",
                 i, {idle_o, run_o, done_o}, addr_vld_o, addr_o, acc_cnt_o, q[i].st, q[i].addr, q[i].acc);
      end
    end
  endtask

  task automatic test_wrap();
    base_addr_i = 8'hFE; stride_i = 8'h02; cnt_val_i = 3; wrap_lim_i = 8'hFE;
    q = {};
    q.push_back(mk(1, 1, 0, 0, SR, 8'hFE, 0));
`ifdef BRAM_ADDR_GEN_WRAP_EN
    q.push_back(mk(0, 1, 0, 0, SR, 8'h01, 1));
    q.push_back(mk(0, 1, 0, 0, SR, 8'h03, 2));
    q.push_back(mk(0, 1, 0, 0, SD, 8'h05, 3));
    q.push_back(mk(0, 1, 0, 0, SI, 8'h05, 3));
`else
    q.push_back(mk(0, 1, 0, 0, SR, 8'h00, 1));
    q.push_back(mk(0, 1, 0, 0, SR, 8'h02, 2));
    q.push_back(mk(0, 1, 0, 0, SD, 8'h04, 3));
    q.push_back(mk(0, 1, 0, 0, SI, 8'h04, 3));
`endif
    foreach (q[i]) begin
      start_i = q[i].start; en_i = q[i].en; abort_i = q[i].abort; reset = q[i].rst;
      tick();
      checks++;
      if ({idle_o, run_o, done_o} !== q[i].st || addr_vld_o !== q[i].st[1] ||
          addr_o !== q[i].addr || acc_cnt_o !== q[i].acc) begin
        errors++;
        $display("FAIL wrap step %0d: got flags=%b vld=%b addr=%h acc=%0d, want flags=%b addr=%h acc=%0d",
                 i, {idle_o, run_o, done_o}, addr_vld_o, addr_o, acc_cnt_o, q[i].st, q[i].addr, q[i].acc);
      end
    end
  endtask

  task automatic test_stall();
    base_addr_i = 8'h20; stride_i = 8'h04; cnt_val_i = 3;
    q = {};
    q.push_back(mk(1, 1, 0, 0, SR, 8'h20, 0));
    q.push_back(mk(0, 1, 0, 0, SR, 8'h24, 1));
    q.push_back(mk(0, 0, 0, 0, SR, 8'h24, 1));
    q.push_back(mk(0, 1, 0, 0, SR, 8'h28, 2));
    q.push_back(mk(0, 1, 0, 0, SD, 8'h2C, 3));
    q.push_back(mk(0, 1, 0, 0, SI, 8'h2C, 3));
    foreach (q[i]) begin
      start_i = q[i].start; en_i = q[i].en; abort_i = q[i].abort; reset = q[i].rst;
      tick();
      checks++;
      if ({idle_o, run_o, done_o} !== q[i].st || addr_vld_o !== q[i].st[1] ||
          addr_o !== q[i].addr || acc_cnt_o !== q[i].acc) begin
        errors++;
        $display("FAIL stall step %0d: got flags=%b vld=%b addr=%h acc=%0d, want flags=%b addr=%h acc=%0d",
                 i, {idle_o, run_o, done_o}, addr_vld_o, addr_o, acc_cnt_o, q[i].st, q[i].addr, q[i].acc);
      end
    end
  endtask

  // Follows test_stall: the address register still holds 8'h2C.
  task automatic test_zero_cnt();
    base_addr_i = 8'h99; stride_i = 8'h01; cnt_val_i = 0;
    q = {};
    q.push_back(mk(1, 1, 0, 0, SD, 8'h2C, 0));
    q.push_back(mk(1, 1, 0, 0, SI, 8'h2C, 0));
    q.push_back(mk(0, 1, 0, 0, SI, 8'h2C, 0));
    foreach (q[i]) begin
      start_i = q[i].start; en_i = q[i].en; abort_i = q[i].abort; reset = q[i].rst;
      tick();
      checks++;
      if ({idle_o, run_o, done_o} !== q[i].st || addr_vld_o !== q[i].st[1] ||
          addr_o !== q[i].addr || acc_cnt_o !== q[i].acc) begin
        errors++;
        $display("FAIL zero_cnt step %0d: got flags=%b vld=%b addr=%h acc=%0d, want flags=%b addr=%h acc=%0d",
                 i, {idle_o, run_o, done_o}, addr_vld_o, addr_o, acc_cnt_o, q[i].st, q[i].addr, q[i].acc);
      end
    end
  endtask

  task automatic test_abort();
    base_addr_i = 8'h40; stride_i = 8'h01; cnt_val_i = 2;
    q = {};
    q.push_back(mk(1, 1, 0, 0, SR, 8'h40, 0));
    q.push_back(mk(0, 1, 0, 0, SR, 8'h41, 1));
    q.push_back(mk(0, 1, 1, 0, SI, 8'h41, 1));
    q.push_back(mk(0, 1, 0, 0, SI, 8'h41, 1));
    foreach (q[i]) begin
      start_i = q[i].start; en_i = q[i].en; abort_i = q[i].abort; reset = q[i].rst;
      tick();
      checks++;
      if ({idle_o, run_o, done_o} !== q[i].st || addr_vld_o !== q[i].st[1] ||
          addr_o !== q[i].addr || acc_cnt_o !== q[i].acc) begin
        errors++;
        $display("FAIL abort step %0d: got flags=%b vld=%b addr=%h acc=%0d, want flags=%b addr=%h acc=%0d",
                 i, {idle_o, run_o, done_o}, addr_vld_o, addr_o, acc_cnt_o, q[i].st, q[i].addr, q[i].acc);
      end
    end
  endtask

  task automatic test_reset_mid();
    base_addr_i = 8'h50; stride_i = 8'h01; cnt_val_i = 5;
    q = {};
    q.push_back(mk(1, 1, 0, 0, SR, 8'h50, 0));
    q.push_back(mk(0, 1, 0, 0, SR, 8'h51, 1));
    q.push_back(mk(0, 1, 0, 0, SR, 8'h52, 2));
    q.push_back(mk(0, 1, 0, 1, SI, 8'h00, 0));
    q.push_back(mk(1, 1, 0, 0, SR, 8'h50, 0));
    q.push_back(mk(0, 1, 0, 0, SR, 8'h51, 1));
    q.push_back(mk(0, 1, 0, 0, SR, 8'h52, 2));
    q.push_back(mk(0, 1, 0, 0, SR, 8'h53, 3));
    q.push_back(mk(0, 1, 0, 0, SR, 8'h54, 4));
    q.push_back(mk(0, 1, 0, 0, SD, 8'h55, 5));
    q.push_back(mk(0, 1, 0, 0, SI, 8'h55, 5));
    foreach (q[i]) begin
      start_i = q[i].start; en_i = q[i].en; abort_i = q[i].abort; reset = q[i].rst;
      tick();
      checks++;
      if ({idle_o, run_o, done_o} !== q[i].st || addr_vld_o !== q[i].st[1] ||
          addr_o !== q[i].addr || acc_cnt_o !== q[i].acc) begin
        errors++;
        $display("FAIL reset_mid step %0d: got flags=%b vld=%b addr=%h acc=%0d, want flags=%b addr=%h acc=%0d",
                 i, {idle_o, run_o, done_o}, addr_vld_o, addr_o, acc_cnt_o, q[i].st, q[i].addr, q[i].acc);
      end
    end
    reset = 0;
  endtask

  // start held high throughout: ignored in RUN and DONE, re-accepted in IDLE
  // even with abort_i asserted there.
  task automatic test_back_to_back();
    base_addr_i = 8'h70; stride_i = 8'h01; cnt_val_i = 1;
    q = {};
    q.push_back(mk(1, 1, 0, 0, SR, 8'h70, 0));
    q.push_back(mk(1, 1, 0, 0, SD, 8'h71, 1));
    q.push_back(mk(1, 1, 0, 0, SI, 8'h71, 1));
    q.push_back(mk(1, 1, 1, 0, SR, 8'h70, 0));
    q.push_back(mk(1, 1, 0, 0, SD, 8'h71, 1));
    q.push_back(mk(0, 1, 0, 0, SI, 8'h71, 1));
    foreach (q[i]) begin
      start_i = q[i].start; en_i = q[i].en; abort_i = q[i].abort; reset = q[i].rst;
      tick();
      checks++;
      if ({idle_o, run_o, done_o} !== q[i].st || addr_vld_o !== q[i].st[1] ||
          addr_o !== q[i].addr || acc_cnt_o !== q[i].acc) begin
        errors++;
        $display("FAIL back_to_back step %0d: got flags=%b vld=%b addr=%h acc=%0d, want flags=%b addr=%h acc=%0d",
                 i, {idle_o, run_o, done_o}, addr_vld_o, addr_o, acc_cnt_o, q[i].st, q[i].addr, q[i].acc);
      end
    end
    start_i = 0; abort_i = 0;
  endtask

  initial begin
    test_reset();
    test_basic();
    test_wrap();
    test_stall();
    test_zero_cnt();
    test_abort();
    test_reset_mid();
    test_back_to_back();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
